// File: rtl/if_id_ctrl_if.sv
// Handshake and control bundle between fetch, the IF/ID buffer and decode.
// The master drives fetch offers and decode-side control; the slave is the buffer.
interface if_id_ctrl_if;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        stall;
    logic        flush;
    logic [1:0]  occupancy;

    modport master (
        output fetch_valid, fetch_instr, fetch_pc, id_ready, stall, flush,
        input  fetch_ready, id_valid, id_instr, id_pc, occupancy
    );

    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc, id_ready, stall, flush,
        output fetch_ready, id_valid, id_instr, id_pc, occupancy
    );
endinterface

// File: rtl/if_id_ctrl.sv
// IF/ID pipeline buffer: 2-entry in-order FIFO of {instr, pc} between fetch and decode.
// All outputs come from registered state only; flush empties the buffer at the next edge.
module if_id_ctrl (
    input logic         clk,
    input logic         rst_n,
    if_id_ctrl_if.slave bus
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0] instr_mem_q [2];
    logic [31:0] pc_mem_q    [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q,  count_d;
    logic        push, pop;

    assign bus.fetch_ready = (count_q != 2'd2);
    assign bus.id_valid    = (count_q != 2'd0);
    assign bus.occupancy   = count_q;

    // An empty buffer presents a NOP so the decoder never sees stale data.
    assign bus.id_instr = (count_q == 2'd0) ? NOP_INSTR : instr_mem_q[rd_ptr_q];
    assign bus.id_pc    = (count_q == 2'd0) ? '0        : pc_mem_q[rd_ptr_q];

    assign push = bus.fetch_valid & bus.fetch_ready & ~bus.flush;
    assign pop  = bus.id_valid & bus.id_ready & ~bus.stall & ~bus.flush;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is unreset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= bus.fetch_instr;
            pc_mem_q[wr_ptr_q]    <= bus.fetch_pc;
        end
    end
endmodule
